dm_cache_refill: RTL and testbench

// - Direct-mapped read cache with miss-refill FSM; sits directly upstream of memory_controller.
// - Accepts CPU word reads, looks up tag/valid, returns the word with a hit flag.
// - On a miss, fetches the 4-word block from main memory via a req/valid handshake and writes the line.
// - Keeps saturating hit/miss counters for hit-rate reporting.

---
 rtl/dm_cache_refill_pkg.sv | 29 ++
 rtl/dm_cache_refill_if.sv | 42 ++++
 rtl/dm_cache_refill_storage.sv | 45 ++++
 rtl/dm_cache_refill.sv | 109 ++++++++++
 tb/tb_dm_cache_refill.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/dm_cache_refill_pkg.sv
// Shared types and constants for the direct-mapped refill cache.
// Address split: tag[14:12], index[11:2], offset[1:0].
package dm_cache_refill_pkg;

   localparam int WORD_W    = 32;
   localparam int ADDR_W    = 15;
   localparam int INDEX_W   = 10;
   localparam int OFFSET_W  = 2;
   localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
   localparam int WORDS     = 1 << OFFSET_W;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_REFILL  = 2'd2
   } state_e;

   typedef logic [WORD_W-1:0] word_t;

   typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [INDEX_W-1:0]  idx;
      logic [OFFSET_W-1:0] off;
   } addr_t;

endpackage

// File: rtl/dm_cache_refill_if.sv
// CPU request/response and memory block-fetch bundle.
// Cache side is the slave; requester/memory side is the master.
interface dm_cache_refill_if #(
   parameter int CNT_W = 16
);
   import dm_cache_refill_pkg::*;

   logic                req_valid;
   logic [ADDR_W-1:0]   req_addr;
   logic                req_ready;
   logic                resp_valid;
   word_t               resp_data;
   logic                resp_hit;
   logic                mem_req;
   logic [ADDR_W-3:0]   mem_block_addr;
   logic                mem_valid;
   word_t               mem_word0;
   word_t               mem_word1;
   word_t               mem_word2;
   word_t               mem_word3;
   logic [CNT_W-1:0]    hit_count;
   logic [CNT_W-1:0]    miss_count;

   modport slave (
      input  req_valid, req_addr,
      input  mem_valid, mem_word0, mem_word1,
      input  mem_word2, mem_word3,
      output req_ready, resp_valid, resp_data,
      output resp_hit, mem_req, mem_block_addr,
      output hit_count, miss_count
   );

   modport master (
      output req_valid, req_addr,
      output mem_valid, mem_word0, mem_word1,
      output mem_word2, mem_word3,
      input  req_ready, resp_valid, resp_data,
      input  resp_hit, mem_req, mem_block_addr,
      input  hit_count, miss_count
   );

endinterface

// File: rtl/dm_cache_refill_storage.sv
// Line storage: valid bits (cleared by reset), tags and 4-word data.
// Combinational read by index, one synchronous full-line write port.
module dm_cache_refill_storage
   import dm_cache_refill_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] rd_idx_i,
   output logic               rd_valid_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output line_t              rd_line_o,
   input  logic               we_i,
   input  logic [INDEX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  line_t              wr_line_i
);

   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   line_t            data_q [LINES];

   // Valid bits: wiped by reset, set when a line is filled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Tag and data arrays: no reset, written only on a line fill.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_line_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dm_cache_refill.sv
// Direct-mapped read cache: lookup FSM, block refill over req/valid,
// registered response and saturating hit/miss counters.
module dm_cache_refill
   import dm_cache_refill_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic              clk,
   input  logic              rst,
   dm_cache_refill_if.slave  bus
);

   state_e              state_q;
   addr_t               addr_q;
   logic                resp_valid_q;
   word_t               resp_data_q;
   logic                resp_hit_q;
   logic                mem_req_q;
   logic [ADDR_W-3:0]   mem_blk_q;
   logic [CNT_W-1:0]    hit_q;
   logic [CNT_W-1:0]    miss_q;

   logic                rd_valid;
   logic [TAG_W-1:0]    rd_tag;
   line_t               rd_line;
   line_t               mem_line;
   logic                hit;
   logic                fill_we;

   assign mem_line = {bus.mem_word3, bus.mem_word2,
                      bus.mem_word1, bus.mem_word0};

   assign hit = rd_valid && (rd_tag == addr_q.tag);

   // A fill only happens on the edge that ends REFILL; reset cancels it.
   assign fill_we = !rst && (state_q == ST_REFILL) && bus.mem_valid;

   dm_cache_refill_storage u_storage (
      .clk_i      (clk),
      .rst_i      (rst),
      .rd_idx_i   (addr_q.idx),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_line_o  (rd_line),
      .we_i       (fill_we),
      .wr_idx_i   (addr_q.idx),
      .wr_tag_i   (addr_q.tag),
      .wr_line_i  (mem_line)
   );

   // Lookup/refill FSM with registered response, fetch and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_hit_q   <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_blk_q    <= '0;
         hit_q        <= '0;
         miss_q       <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  addr_q  <= bus.req_addr;
                  state_q <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               if (hit) begin
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= 1'b1;
                  resp_data_q  <= rd_line[addr_q.off];
                  if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
                  state_q      <= ST_IDLE;
               end else begin
                  mem_req_q <= 1'b1;
                  mem_blk_q <= {addr_q.tag, addr_q.idx};
                  state_q   <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               if (bus.mem_valid) begin
                  mem_req_q    <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= 1'b0;
                  resp_data_q  <= mem_line[addr_q.off];
                  if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready      = (state_q == ST_IDLE);
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_data      = resp_data_q;
   assign bus.resp_hit       = resp_hit_q;
   assign bus.mem_req        = mem_req_q;
   assign bus.mem_block_addr = mem_blk_q;
   assign bus.hit_count      = hit_q;
   assign bus.miss_count     = miss_q;

endmodule

// File: tb/tb_dm_cache_refill.sv
// Directed bench for dm_cache_refill; counters narrowed to 8 bits
// so saturation is reached in a few hundred requests.
module tb_dm_cache_refill;

   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   dm_cache_refill_if #(.CNT_W(CW)) bus ();

   dm_cache_refill #(.CNT_W(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic set_words(input logic [31:0] base);
      bus.mem_word0 = base;
      bus.mem_word1 = base + 32'd1;
      bus.mem_word2 = base + 32'd2;
      bus.mem_word3 = base + 32'd3;
   endtask

   // Present a request in IDLE; returns at the negedge after acceptance.
   task automatic send(input logic [14:0] a);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic hit_rd(input logic [14:0] a,
                         input logic [31:0] exp_w,
                         input int exp_hits);
      send(a);
      @(negedge clk);
      chk("hit_rv", 32'(bus.resp_valid), 32'd1);
      chk("hit_flag", 32'(bus.resp_hit), 32'd1);
      chk("hit_data", bus.resp_data, exp_w);
      chk("hit_cnt", 32'(bus.hit_count), 32'(exp_hits));
      chk("hit_mreq", 32'(bus.mem_req), 32'd0);
   endtask

   task automatic miss_rd(input logic [14:0] a,
                          input logic [31:0] base,
                          input int dly,
                          input int exp_miss);
      logic [31:0] ew;
      ew = base + 32'(a[1:0]);
      send(a);
      @(negedge clk);
      chk("miss_mreq", 32'(bus.mem_req), 32'd1);
      chk("miss_blk", 32'(bus.mem_block_addr), 32'(a[14:2]));
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         chk("hold_mreq", 32'(bus.mem_req), 32'd1);
         chk("hold_blk", 32'(bus.mem_block_addr), 32'(a[14:2]));
         chk("hold_rdy", 32'(bus.req_ready), 32'd0);
      end
      bus.mem_valid = 1'b1;
      set_words(base);
      @(negedge clk);
      bus.mem_valid = 1'b0;
      chk("miss_rv", 32'(bus.resp_valid), 32'd1);
      chk("miss_flag", 32'(bus.resp_hit), 32'd0);
      chk("miss_data", bus.resp_data, ew);
      chk("miss_cnt", 32'(bus.miss_count), 32'(exp_miss));
      chk("miss_mdrop", 32'(bus.mem_req), 32'd0);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.mem_valid = 1'b0;
      set_words(32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_rdy", 32'(bus.req_ready), 32'd1);
      chk("rst_rv", 32'(bus.resp_valid), 32'd0);
      chk("rst_data", bus.resp_data, 32'd0);
      chk("rst_hit", 32'(bus.resp_hit), 32'd0);
      chk("rst_mreq", 32'(bus.mem_req), 32'd0);
      chk("rst_blk", 32'(bus.mem_block_addr), 32'd0);
      chk("rst_hcnt", 32'(bus.hit_count), 32'd0);
      chk("rst_mcnt", 32'(bus.miss_count), 32'd0);

      // Cold miss, then response must be a single-cycle pulse.
      miss_rd(15'h0005, 32'hA0A0_0000, 3, 1);
      @(negedge clk);
      chk("pulse_rv", 32'(bus.resp_valid), 32'd0);
      chk("pulse_keep", bus.resp_data, 32'hA0A0_0001);

      // Hit on the filled line.
      hit_rd(15'h0007, 32'hA0A0_0003, 1);

      // Conflict on index 1: tag 1 evicts tag 0, which then misses again.
      miss_rd(15'h1004, 32'hB0B0_0000, 1, 2);
      miss_rd(15'h0004, 32'hA0A0_0000, 0, 3);

      // Long handshake hold.
      miss_rd(15'h2008, 32'hC0C0_0000, 10, 4);

      // Stray mem_valid in IDLE must not touch the arrays.
      bus.mem_valid = 1'b1;
      set_words(32'hD0D0_0000);
      @(negedge clk);
      bus.mem_valid = 1'b0;
      chk("stray_rv", 32'(bus.resp_valid), 32'd0);
      chk("stray_mcnt", 32'(bus.miss_count), 32'd4);
      hit_rd(15'h2009, 32'hC0C0_0001, 2);

      // Reset while refilling.
      send(15'h0060);
      @(negedge clk);
      chk("pre_rst_mreq", 32'(bus.mem_req), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_mreq", 32'(bus.mem_req), 32'd0);
      chk("mid_rst_rdy", 32'(bus.req_ready), 32'd1);
      chk("mid_rst_mcnt", 32'(bus.miss_count), 32'd0);
      bus.mem_valid = 1'b1;
      set_words(32'hE0E0_0000);
      @(negedge clk);
      bus.mem_valid = 1'b0;
      chk("late_rv", 32'(bus.resp_valid), 32'd0);
      miss_rd(15'h0005, 32'hA0A0_0000, 1, 1);
      miss_rd(15'h0060, 32'hE0E0_0000, 0, 2);

      // Saturation of the hit counter.
      for (int i = 0; i < 300; i++) begin
         send(15'h0005);
         @(negedge clk);
      end
      chk("sat_hcnt", 32'(bus.hit_count), 32'hFF);
      chk("sat_mcnt", 32'(bus.miss_count), 32'd2);
      hit_rd(15'h0006, 32'hA0A0_0002, 255);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
